// File: rtl/spypath_meas_ctrl_pkg.sv
// Shared types and default sizing for the spy-path delay measurement controller.
package spypath_meas_ctrl_pkg;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned TrialWDefault     = 8;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StSettle,
    StDone
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for the asynchronous spy-path chain output.
module sync_ff #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [Depth-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Depth-2:0], d_i};
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/spypath_meas_ctrl.sv
// Launches transitions into a spy path chain and measures per-trial propagation delay,
// accumulating sum/min/max over a configurable number of trials.
module spypath_meas_ctrl
  import spypath_meas_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned TRIAL_W     = TrialWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [TRIAL_W-1:0]         num_trials,
  input  logic [CNT_W-1:0]           timeout,
  input  logic [CNT_W-1:0]           settle,
  output logic                       path_input,
  input  logic                       path_result,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic [CNT_W+TRIAL_W-1:0]   sum_delay,
  output logic [CNT_W-1:0]           min_delay,
  output logic [CNT_W-1:0]           max_delay,
  output logic [TRIAL_W-1:0]         trials_done
);

  localparam int unsigned SumW = CNT_W + TRIAL_W;

  state_e               state_q, state_d;
  logic                 path_input_q, path_input_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TRIAL_W-1:0]   num_trials_q, num_trials_d;
  logic [CNT_W-1:0]     timeout_q, timeout_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [SumW-1:0]      sum_q, sum_d;
  logic [CNT_W-1:0]     min_q, min_d;
  logic [CNT_W-1:0]     max_q, max_d;
  logic [TRIAL_W-1:0]   trials_q, trials_d;
  logic                 timed_out_q, timed_out_d;
  logic                 path_sync;
  logic                 match;

  sync_ff #(
    .Depth(SYNC_STAGES)
  ) u_sync_ff (
    .clk(clk),
    .rst(rst),
    .d_i(path_result),
    .q_o(path_sync)
  );

  assign match = (path_sync == path_input_q);

  always_comb begin
    state_d      = state_q;
    path_input_d = path_input_q;
    cnt_d        = cnt_q;
    num_trials_d = num_trials_q;
    timeout_d    = timeout_q;
    settle_d     = settle_q;
    sum_d        = sum_q;
    min_d        = min_q;
    max_d        = max_q;
    trials_d     = trials_q;
    timed_out_d  = timed_out_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          timed_out_d = 1'b0;
          if (num_trials != '0) begin
            num_trials_d = num_trials;
            timeout_d    = timeout;
            settle_d     = settle;
            sum_d        = '0;
            trials_d     = '0;
            min_d        = '1;
            max_d        = '0;
            state_d      = StLaunch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLaunch: begin
        path_input_d = ~path_input_q;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        // A match wins over a coincident timeout.
        if (match) begin
          sum_d    = sum_q + SumW'(cnt_q);
          trials_d = trials_q + TRIAL_W'(1);
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
          cnt_d = '0;
          if (trials_q == num_trials_q - TRIAL_W'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StSettle;
          end
        end else if (cnt_q == timeout_q) begin
          timed_out_d = 1'b1;
          state_d     = StDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StSettle: begin
        // Counter reused as settle timer; settle of 0 or 1 both take one cycle.
        if ((settle_q == '0) || (cnt_q == settle_q - CNT_W'(1))) begin
          state_d = StLaunch;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      path_input_q <= 1'b0;
      cnt_q        <= '0;
      num_trials_q <= '0;
      timeout_q    <= '0;
      settle_q     <= '0;
      sum_q        <= '0;
      min_q        <= '1;
      max_q        <= '0;
      trials_q     <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      path_input_q <= path_input_d;
      cnt_q        <= cnt_d;
      num_trials_q <= num_trials_d;
      timeout_q    <= timeout_d;
      settle_q     <= settle_d;
      sum_q        <= sum_d;
      min_q        <= min_d;
      max_q        <= max_d;
      trials_q     <= trials_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign path_input  = path_input_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign timed_out   = timed_out_q;
  assign sum_delay   = sum_q;
  assign min_delay   = min_q;
  assign max_delay   = max_q;
  assign trials_done = trials_q;

endmodule

// File: doc/spypath_meas_ctrl.md
SPYPATH_MEAS_CTRL -- requirements
Module: spypath_meas_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of per-trial delay counter.
REQ-002 SHALL have parameter TRIAL_W, default 8, meaning width of trial-count configuration.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning flops in the path_result synchronizer (legal 2..4).
REQ-004 SHALL have one clock and a synchronous, active-high reset, exactly as listed here: clk input 1, rising-edge clock for all logic.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a measurement run; ignored unless busy=0.
REQ-007 num_trials  input  TRIAL_W  launches per run; sampled on an accepted start.
REQ-008 timeout  input  CNT_W  per-trial cycle limit; sampled on an accepted start.
REQ-009 settle  input  CNT_W  idle cycles between trials; sampled on an accepted start.
REQ-010 path_input  output  1  launch signal driving the spy path chain input.
REQ-011 path_result  input  1  asynchronous spy path chain output.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 timed_out  output  1  run aborted by timeout; valid from done until the next accepted start.
REQ-015 sum_delay  output  CNT_W+TRIAL_W  sum of per-trial delays.
REQ-016 min_delay, max_delay  output  CNT_W each  extreme per-trial delays.
REQ-017 trials_done  output  TRIAL_W  completed (non-timed-out) trials.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, SETTLE, DONE.
REQ-019 IDLE: start=1 with num_trials!=0 SHALL latch config, clear sum/trials_done/timed_out, set min_delay to all-ones and max_delay to 0, then go to LAUNCH; start with num_trials=0 SHALL go directly to DONE with timed_out=0.
REQ-020 LAUNCH: path_input SHALL toggle; the delay counter SHALL clear; next state WAIT; single cycle.
REQ-021 WAIT: counter SHALL increment by 1 per cycle; trial SHALL end when synchronized path_result equals path_input.
REQ-022 Measured delay SHALL be the counter value on the cycle of the match and SHALL include the SYNC_STAGES latency, which is not subtracted.
REQ-023 On match: sum_delay += delay, min/max update, trials_done += 1; then go to SETTLE, or to DONE if trials_done reaches num_trials.
REQ-024 When the counter equals timeout without a match, the FSM SHALL set timed_out=1, keep the accumulators unchanged, and go to DONE; timeout=0 SHALL time out on the first WAIT cycle.
REQ-025 A match and a timeout in the same cycle SHALL be treated as a match.
REQ-026 The counter SHALL saturate at all-ones and SHALL never wrap.
REQ-027 sum_delay SHALL be wide enough never to overflow.
REQ-028 SETTLE SHALL wait settle cycles (0 means pass through in 1 cycle), then go to LAUNCH.
REQ-029 DONE SHALL pulse done for 1 cycle, drop busy, and return to IDLE; results SHALL hold until the next accepted start.
REQ-030 start while busy=1 SHALL be ignored with no side effect.
REQ-031 path_input SHALL change only in LAUNCH.

Reset
REQ-032 rst SHALL force IDLE and clear the synchronizer chain.
REQ-033 rst SHALL drive path_input, busy, done, timed_out, sum_delay, max_delay and trials_done to 0, and min_delay to all-ones.
REQ-034 rst mid-run SHALL abort with no done pulse; rst SHALL take priority over start.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and default parameter constants.
REQ-036 The path_result synchronizer SHALL be a sub-module named sync_ff, parameterized by depth, marked keep/ASYNC_REG.
REQ-037 The datapath SHALL be a single module with no inferred latches.

Verification
REQ-038 num_trials=4, path model delay 10 cycles, settle=3 -> done, sum=4*(10+SYNC_STAGES), min=max=12, trials_done=4, timed_out=0.
REQ-039 Delays 5,9,7 over 3 trials -> min=7, max=11, sum=27 with SYNC_STAGES=2.
REQ-040 Path stuck (no transition), timeout=50 -> done ~51 cycles after LAUNCH, timed_out=1, trials_done=0.
REQ-041 start with num_trials=0 -> done on the next cycle; path_input unchanged.
REQ-042 rst asserted in WAIT of trial 2 -> no done, all outputs at reset values; a new start runs normally.
REQ-043 start pulsed during busy, and match coinciding with timeout -> start ignored; trial counted as a match.
